sprite_mem_arbiter: RTL
=======================

# sprite_mem_arbiter

Two-requester arbiter sharing one 256x16 single-port sprite memory, such as the wall sprite store. Requester 0 is the VGA sprite renderer (read-only, latency-critical). Requester 1 is the loader/debug path (read or byte-enabled write). The block sits between both requesters and the memory's Avalon-style port, grants one access per cycle, and routes the 1-cycle-latency read data back to the owning requester with a valid strobe.

## Interface
Parameters:
- ADDR_W, 8, memory address width (256 words)
- DATA_W, 16, memory data width
- STARVE_LIMIT, 15, consecutive denied cycles of requester 1 before it wins one conflict; 0 = strict requester-0 priority
- CNT_W, 4, starvation counter width; must hold STARVE_LIMIT

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high
- r0_req  in  1  renderer read request, held until granted
- r0_addr  in  ADDR_W  renderer word address
- r0_gnt  out  1  request accepted this cycle
- r0_rvalid  out  1  r0_rdata valid
- r0_rdata  out  DATA_W  read data
- r1_req  in  1  loader request, held until granted
- r1_write  in  1  1 = write, 0 = read
- r1_addr  in  ADDR_W  word address
- r1_wdata  in  DATA_W  write data
- r1_be  in  2  byte enables (write only)
- r1_gnt  out  1  request accepted this cycle
- r1_rvalid  out  1  r1_rdata valid (reads only)
- r1_rdata  out  DATA_W  read data
- mem_address  out  ADDR_W  to memory address
- mem_chipselect  out  1  access this cycle
- mem_write  out  1  write strobe
- mem_debugaccess  out  1  equals mem_write (memory gates writes on it)
- mem_byteenable  out  2  byte enables; 2'b11 on reads
- mem_writedata  out  DATA_W  write data
- mem_clken  out  1  constant 1
- mem_readdata  in  DATA_W  memory output, valid 1 cycle after address

## Operation
- Each cycle selects at most one winner; grant, mem_* are combinational from current req and starvation state.
- Only r0_req: r0 wins. Only r1_req: r1 wins. Both: r0 wins unless override active (STARVE_LIMIT != 0 and starve_cnt == STARVE_LIMIT), then r1 wins.
- starve_cnt: increments (saturating at STARVE_LIMIT) each cycle r1_req=1 and r1_gnt=0; clears to 0 on any r1_gnt; holds when r1_req=0.
- Winner drives mem_address/write/byteenable/writedata; mem_chipselect=1. No winner: chipselect=0, write=0, address holds last value (don't-care).
- Registered tag {valid, owner} captured on each granted read; next cycle, owner's rvalid=1, rdata=mem_readdata (both rdata outputs may mirror mem_readdata; only rvalid qualifies).
- r1 writes: no rvalid. Back-to-back grants pipeline: one read result per cycle.
- r1_be ignored on reads.

## Timing
- Reset values: r0_gnt=r1_gnt=0, r0_rvalid=r1_rvalid=0, mem_chipselect=mem_write=mem_debugaccess=0, starve_cnt=0, tag cleared.
- While reset=1 all grants forced 0 regardless of requests.
- Read latency: grant in cycle N -> rvalid in cycle N+1, exactly one cycle wide.
- Write commits at the edge ending the grant cycle; read of same address granted in N+1 returns new data.
- Reset asserted in cycle N+1 after a grant in N: rvalid suppressed; in-flight read discarded.
- Requesters must hold req/addr/data stable until gnt; dropping req before gnt is legal and cancels with no side effect.
- Override grant clears starve_cnt in the same edge, so r0 regains priority next cycle.

## Structure
- Shared package sprite_mem_pkg: ADDR_W/DATA_W constants, owner encoding (OWN_R0=0, OWN_R1=1).
- Optional sub-module sprite_starve_ctr (saturating counter with clear, outputs override flag); selection mux and tag register in the top.

## Test plan
- Only r0_req, addr 0x10..0x13 back-to-back, memory preloaded 0xA000+addr -> r0_gnt each cycle, r0_rvalid cycles N+1..N+4 with 0xA010..0xA013, r1_rvalid=0.
- r1 write addr 0x20 data 0x1234 be=2'b01 over 0xFFFF, then r1 read 0x20 -> r1_rvalid once, r1_rdata=0xFF34.
- r0_req and r1_req held continuously, STARVE_LIMIT=15 -> r1_gnt exactly once every 16 cycles, r0_gnt all other cycles.
- STARVE_LIMIT=0, both held 100 cycles -> r1_gnt never asserted; drop r0_req -> r1_gnt same cycle.
- r0 read granted at cycle N, reset at N+1 -> r0_rvalid=0 at N+1, all outputs at reset values, starve_cnt=0.
- r1 asserts req then drops it before grant while r0 busy -> no memory write, starve_cnt holds then clears only on next r1 grant.

Source files
------------

// File: rtl/sprite_mem_pkg.sv
// Shared definitions for the sprite memory arbiter: memory geometry,
// requester owner encoding and the read-tag layout.
package sprite_mem_pkg;

  localparam int SPRITE_ADDR_W = 8;
  localparam int SPRITE_DATA_W = 16;
  localparam int BE_W          = 2;

  localparam logic [BE_W-1:0] BE_ALL = {BE_W{1'b1}};

  typedef enum logic {
    OWN_R0 = 1'b0,
    OWN_R1 = 1'b1
  } owner_e;

  // In-flight read marker: which requester gets the data returning next cycle.
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

  // Reads always fetch the whole word; only writes honour the byte lanes.
  function automatic logic [BE_W-1:0] access_be(input logic write, input logic [BE_W-1:0] be);
    return write ? be : BE_ALL;
  endfunction

endpackage

// File: rtl/sprite_starve_ctr.sv
// Counts consecutive cycles in which the loader is kept waiting and raises
// override once the limit is reached, so the loader wins the next conflict.
module sprite_starve_ctr #(
  parameter int LIMIT = 15,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic gnt,
  output logic override
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt;

  // Saturating count of denied cycles; any grant restarts the window,
  // an idle requester leaves it untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (gnt) begin
      cnt <= '0;
    end else if (req && (cnt != LIMIT_C)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // A limit of zero means the renderer always wins conflicts.
  assign override = (LIMIT != 0) && (cnt == LIMIT_C);

endmodule

// File: rtl/sprite_mem_arbiter.sv
// Two-requester arbiter in front of a single-port 256x16 sprite memory.
// Requester 0 (renderer) has priority; requester 1 (loader) is protected
// from starvation by a bounded wait. Read data returns one cycle after the
// grant and is steered to its owner by a registered tag.
module sprite_mem_arbiter
  import sprite_mem_pkg::*;
#(
  parameter int ADDR_W       = SPRITE_ADDR_W,
  parameter int DATA_W       = SPRITE_DATA_W,
  parameter int STARVE_LIMIT = 15,
  parameter int CNT_W        = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              r0_req,
  input  logic [ADDR_W-1:0] r0_addr,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,

  input  logic              r1_req,
  input  logic              r1_write,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  input  logic [BE_W-1:0]   r1_be,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,

  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_debugaccess,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic              override;
  logic              sel_r0;
  logic              sel_r1;
  logic [ADDR_W-1:0] addr_q;
  rd_tag_t           tag_q;

  sprite_starve_ctr #(
    .LIMIT (STARVE_LIMIT),
    .CNT_W (CNT_W)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .req      (r1_req),
    .gnt      (sel_r1),
    .override (override)
  );

  // Pick at most one winner; the loader only beats a concurrent renderer
  // request when its wait has hit the limit. Nothing is granted in reset.
  always_comb begin
    sel_r0 = 1'b0;
    sel_r1 = 1'b0;
    if (!reset) begin
      if (r0_req && !(r1_req && override)) begin
        sel_r0 = 1'b1;
      end else if (r1_req) begin
        sel_r1 = 1'b1;
      end
    end
  end

  assign r0_gnt = sel_r0;
  assign r1_gnt = sel_r1;

  // Steer the winner onto the memory port; an idle port keeps the last address.
  always_comb begin
    mem_address    = addr_q;
    mem_write      = 1'b0;
    mem_byteenable = BE_ALL;
    mem_writedata  = '0;
    if (sel_r0) begin
      mem_address = r0_addr;
    end else if (sel_r1) begin
      mem_address    = r1_addr;
      mem_write      = r1_write;
      mem_byteenable = access_be(r1_write, r1_be);
      mem_writedata  = r1_wdata;
    end
  end

  assign mem_chipselect  = sel_r0 | sel_r1;
  assign mem_debugaccess = mem_write;
  assign mem_clken       = 1'b1;

  // Remember the last driven address so the idle bus does not toggle.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
    end else if (mem_chipselect) begin
      addr_q <= mem_address;
    end
  end

  // Tag every granted read so its data can be routed back next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q <= '0;
    end else begin
      tag_q.valid <= sel_r0 | (sel_r1 & ~r1_write);
      tag_q.owner <= sel_r1 ? OWN_R1 : OWN_R0;
    end
  end

  // Reset in the return cycle discards the in-flight read.
  assign r0_rvalid = tag_q.valid && (tag_q.owner == OWN_R0) && !reset;
  assign r1_rvalid = tag_q.valid && (tag_q.owner == OWN_R1) && !reset;
  assign r0_rdata  = mem_readdata;
  assign r1_rdata  = mem_readdata;

endmodule
